// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: EX-stage forwarding selects over NUM_FWD_STAGES
// downstream stages, ID-stage load-use detection, and a registered scoreboard
// of destination registers owned by in-flight multi-cycle (MUL/DIV) ops.
// Optional hazard statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard_unit #(
  parameter  int NUM_SRC        = 2,
  parameter  int NUM_FWD_STAGES = 2,
  parameter  int MAX_MC         = 4,
  localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1),
  localparam int CNT_W          = $clog2(MAX_MC + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*5-1:0]        ex_rs_addr,
  input  logic [NUM_FWD_STAGES*5-1:0] stage_rd_addr,
  input  logic [NUM_FWD_STAGES-1:0]   stage_reg_write,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  input  logic                        id_valid,
  input  logic [NUM_SRC*5-1:0]        id_rs_addr,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic                        id_is_mc,
  input  logic [4:0]                  id_rd_addr,
  input  logic [4:0]                  ex_rd_addr,
  input  logic                        ex_is_load,
  input  logic                        mc_issue,
  input  logic                        mc_done,
  input  logic [4:0]                  mc_done_rd,
  output logic                        stall,
  output logic [31:0]                 sb_busy,
  output logic [CNT_W-1:0]            mc_count
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                 stat_load_use,
  output logic [31:0]                 stat_sb_stall,
  output logic [31:0]                 stat_struct_stall
`endif
);

  logic [31:0]      r_sb_busy;
  logic [CNT_W-1:0] r_mc_count;
  logic [31:0]      w_sb_next;
  logic [4:0]       w_ex_rs;
  logic [4:0]       w_id_rs;
  logic             w_load_use;
  logic             w_sb_haz;
  logic             w_waw;
  logic             w_struct;

  // Forward select per EX source: lowest (youngest) matching stage wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    fwd_sel = '0;
    w_ex_rs = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ex_rs = ex_rs_addr[5*i +: 5];
      // Walk oldest to youngest so the youngest match overwrites the rest.
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
        if (stage_reg_write[k] && stage_rd_addr[5*k +: 5] != 5'd0 &&
            stage_rd_addr[5*k +: 5] == w_ex_rs)
          fwd_sel[SEL_W*i +: SEL_W] = SEL_W'(k + 1);
      end
    end
  end

  // ID-stage hazard terms; a completing op's register bypasses via WB.
  always_comb begin
    w_load_use = 1'b0;
    w_sb_haz   = 1'b0;
    w_id_rs    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_id_rs = id_rs_addr[5*i +: 5];
      if (id_valid && id_rs_used[i] && ex_is_load && ex_rd_addr != 5'd0 &&
          ex_rd_addr == w_id_rs)
        w_load_use = 1'b1;
      if (id_valid && id_rs_used[i] && w_id_rs != 5'd0 && r_sb_busy[w_id_rs] &&
          !(mc_done && mc_done_rd == w_id_rs))
        w_sb_haz = 1'b1;
    end
    w_waw    = id_valid && id_rd_addr != 5'd0 && r_sb_busy[id_rd_addr] &&
               !(mc_done && mc_done_rd == id_rd_addr);
    w_struct = id_valid && id_is_mc && r_mc_count == CNT_W'(MAX_MC) && !mc_done;
  end

  assign stall    = w_load_use | w_sb_haz | w_waw | w_struct;
  assign sb_busy  = r_sb_busy;
  assign mc_count = r_mc_count;

  // Next scoreboard: clear on completion, then set on issue so the set wins.
  always_comb begin
    w_sb_next = r_sb_busy;
    if (mc_done)
      w_sb_next[mc_done_rd] = 1'b0;
    if (mc_issue && id_rd_addr != 5'd0)
      w_sb_next[id_rd_addr] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  // Scoreboard register; reset drops all outstanding ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset in full;
    // state updates use non-blocking assignments to avoid simulation races.
    if (!rst_n) r_sb_busy <= '0;
    else        r_sb_busy <= w_sb_next;
  end

  // Outstanding op counter; saturates at both ends instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_mc_count <= '0;
    else if (mc_issue && !mc_done && r_mc_count != CNT_W'(MAX_MC))
      r_mc_count <= r_mc_count + CNT_W'(1);
    else if (mc_done && !mc_issue && r_mc_count != '0)
      r_mc_count <= r_mc_count - CNT_W'(1);
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_load_use;
  logic [31:0] r_stat_sb_stall;
  logic [31:0] r_stat_struct_stall;

  // Saturating per-term stall counters; WAW hits count as scoreboard stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_load_use     <= '0;
      r_stat_sb_stall     <= '0;
      r_stat_struct_stall <= '0;
    end else begin
      if (w_load_use && r_stat_load_use != '1)
        r_stat_load_use <= r_stat_load_use + 32'd1;
      if ((w_sb_haz || w_waw) && r_stat_sb_stall != '1)
        r_stat_sb_stall <= r_stat_sb_stall + 32'd1;
      if (w_struct && r_stat_struct_stall != '1)
        r_stat_struct_stall <= r_stat_struct_stall + 32'd1;
    end
  end

  assign stat_load_use     = r_stat_load_use;
  assign stat_sb_stall     = r_stat_sb_stall;
  assign stat_struct_stall = r_stat_struct_stall;
`endif

  // Protocol checks on the issue/complete handshake.
  a_issue_while_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(mc_issue && stall));
  a_issue_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(mc_issue && !mc_done && r_mc_count == CNT_W'(MAX_MC)));
  a_done_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(mc_done && r_mc_count == '0));
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(mc_done && !r_sb_busy[mc_done_rd]));

endmodule
